// File: rtl/multi_channel_down_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_down_timer_pkg
// Brief    : Shared constants and helpers for the multi-channel down timer.
// Revision : 1.0 - initial release
// ============================================================================
package multi_channel_down_timer_pkg;

    // Per-channel mode encoding
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // Width of the shared prescaler counter; never narrower than one bit
    function automatic int presc_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage
`default_nettype wire

// File: rtl/down_timer_channel.sv
`default_nettype none
// ============================================================================
// Module   : down_timer_channel
// Brief    : One loadable down-counter with one-shot / auto-reload modes,
//            a one-cycle terminal-count pulse and a sticky done flag.
// Revision : 1.0 - initial release
// ============================================================================
module down_timer_channel #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    input  logic             clear_done,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             done
);
    import multi_channel_down_timer_pkg::*;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             armed_q, armed_d;
    logic             done_q, done_d;
    logic             tc_q, tc_d;

    // Next-state: load beats tick beats hold; completion beats clear_done
    always_comb begin
        q_d      = q_q;
        reload_d = reload_q;
        armed_d  = armed_q;
        done_d   = done_q;
        tc_d     = 1'b0;

        if (clear_done) begin
            done_d = 1'b0;
        end

        if (load) begin
            q_d      = limit;
            reload_d = limit;
            armed_d  = 1'b1;
            done_d   = 1'b0;
        end else if (tick && armed_q) begin
            if (q_q != '0) begin
                q_d = q_q - WIDTH'(1);
            end else begin
                // Terminal tick: the count at zero has been observed for one tick
                tc_d = 1'b1;
                if (mode == MODE_ONESHOT) begin
                    armed_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    q_d = reload_q;
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q      <= '0;
            reload_q <= '0;
            armed_q  <= 1'b0;
            done_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            q_q      <= q_d;
            reload_q <= reload_d;
            armed_q  <= armed_d;
            done_q   <= done_d;
            tc_q     <= tc_d;
        end
    end

    assign Q    = q_q;
    assign tc   = tc_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/multi_channel_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_down_timer
// Brief    : CHANNELS independent down-counters sharing an enable-gated
//            prescaler that produces the common count tick.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_down_timer #(
    parameter int WIDTH    = 7,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       clear_done,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       done
);
    import multi_channel_down_timer_pkg::*;

    localparam int            PW      = presc_width(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcount_q, pcount_d;
    logic          tick;

    // Tick fires on the last enabled cycle of each prescaler period
    assign tick = en && (pcount_q == PS_LAST);

    // Prescaler next-state: advances only while enabled, wraps after PS_LAST
    always_comb begin
        pcount_d = pcount_q;
        if (en) begin
            pcount_d = (pcount_q == PS_LAST) ? '0 : pcount_q + PW'(1);
        end
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcount_q <= '0;
        end else begin
            pcount_q <= pcount_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        down_timer_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .load       (load[i]),
            .limit      (limit[i*WIDTH +: WIDTH]),
            .mode       (mode[i]),
            .clear_done (clear_done[i]),
            .Q          (Q[i*WIDTH +: WIDTH]),
            .tc         (tc[i]),
            .done       (done[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_down_timer
// Brief    : Self-checking bench for multi_channel_down_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_down_timer;

    localparam int W  = 7;
    localparam int CH = 4;
    localparam int NV = 25;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic [CH-1:0]   load;
    logic [CH*W-1:0] limit;
    logic [CH-1:0]   mode;
    logic [CH-1:0]   clear_done;

    logic [CH*W-1:0] q1, q4;
    logic [CH-1:0]   tc1, tc4, done1, done4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_channel_down_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .limit(limit),
        .mode(mode), .clear_done(clear_done), .Q(q1), .tc(tc1), .done(done1)
    );

    multi_channel_down_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .load(load), .limit(limit),
        .mode(mode), .clear_done(clear_done), .Q(q4), .tc(tc4), .done(done4)
    );

    typedef struct {
        logic            rst;
        logic            en;
        logic [CH-1:0]   ld;
        logic [CH*W-1:0] lim;
        logic [CH-1:0]   md;
        logic [CH-1:0]   clr;
        logic [CH*W-1:0] eq;
        logic [CH-1:0]   etc;
        logic [CH-1:0]   edone;
    } vec_t;

    vec_t vt[NV];

    function automatic logic [CH*W-1:0] pk(input logic [W-1:0] a3, input logic [W-1:0] a2,
                                           input logic [W-1:0] a1, input logic [W-1:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic r, input logic e, input logic [3:0] ld,
                                input logic [CH*W-1:0] lim, input logic [3:0] md,
                                input logic [3:0] clr, input logic [CH*W-1:0] eq,
                                input logic [3:0] etc, input logic [3:0] ed);
        vec_t v;
        v.rst = r; v.en = e; v.ld = ld; v.lim = lim; v.md = md; v.clr = clr;
        v.eq = eq; v.etc = etc; v.edone = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b1; en = 1'b0; load = '0; limit = '0; mode = '0; clear_done = '0;
    endtask

    initial begin
        logic [W-1:0] exp0;
        idle_inputs();

        // Reset, one-shot ch0, auto-reload ch1, priority cases (PRESCALE=1)
        vt[0]  = mk(0, 1, 4'hF, pk(5,5,5,5), 4'h0, 4'h0, pk(0,0,0,0), 4'h0, 4'h0);
        vt[1]  = mk(0, 1, 4'hF, pk(5,5,5,5), 4'h0, 4'h0, pk(0,0,0,0), 4'h0, 4'h0);
        vt[2]  = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h0, 4'h0, pk(0,0,0,0), 4'h0, 4'h0);
        vt[3]  = mk(1, 1, 4'h1, pk(0,0,0,3), 4'h0, 4'h0, pk(0,0,0,3), 4'h0, 4'h0);
        vt[4]  = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h0, 4'h0, pk(0,0,0,2), 4'h0, 4'h0);
        vt[5]  = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h0, 4'h0, pk(0,0,0,1), 4'h0, 4'h0);
        vt[6]  = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h0, 4'h0, pk(0,0,0,0), 4'h0, 4'h0);
        vt[7]  = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h0, 4'h0, pk(0,0,0,0), 4'h1, 4'h1);
        vt[8]  = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h0, 4'h0, pk(0,0,0,0), 4'h0, 4'h1);
        vt[9]  = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h0, 4'h1, pk(0,0,0,0), 4'h0, 4'h0);
        vt[10] = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h0, 4'h0, pk(0,0,0,0), 4'h0, 4'h0);
        vt[11] = mk(1, 1, 4'h2, pk(0,0,2,0), 4'h2, 4'h0, pk(0,0,2,0), 4'h0, 4'h0);
        vt[12] = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h2, 4'h0, pk(0,0,1,0), 4'h0, 4'h0);
        vt[13] = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h2, 4'h0, pk(0,0,0,0), 4'h0, 4'h0);
        vt[14] = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h2, 4'h0, pk(0,0,2,0), 4'h2, 4'h0);
        vt[15] = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h2, 4'h0, pk(0,0,1,0), 4'h0, 4'h0);
        vt[16] = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h2, 4'h0, pk(0,0,0,0), 4'h0, 4'h0);
        vt[17] = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h2, 4'h0, pk(0,0,2,0), 4'h2, 4'h0);
        vt[18] = mk(1, 1, 4'h8, pk(1,0,0,0), 4'h2, 4'h0, pk(1,0,1,0), 4'h0, 4'h0);
        vt[19] = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h2, 4'h0, pk(0,0,0,0), 4'h0, 4'h0);
        vt[20] = mk(1, 1, 4'h8, pk(5,0,0,0), 4'h2, 4'h0, pk(5,0,2,0), 4'h2, 4'h0);
        vt[21] = mk(1, 0, 4'h0, pk(0,0,0,0), 4'h2, 4'h0, pk(5,0,2,0), 4'h0, 4'h0);
        vt[22] = mk(1, 0, 4'h4, pk(0,0,0,0), 4'h2, 4'h0, pk(5,0,2,0), 4'h0, 4'h0);
        vt[23] = mk(1, 1, 4'h0, pk(0,0,0,0), 4'h2, 4'h4, pk(4,0,1,0), 4'h4, 4'h4);
        vt[24] = mk(1, 0, 4'h0, pk(0,0,0,0), 4'h2, 4'h0, pk(4,0,1,0), 4'h0, 4'h4);

        for (int i = 0; i < NV; i++) begin
            reset = vt[i].rst; en = vt[i].en; load = vt[i].ld; limit = vt[i].lim;
            mode = vt[i].md; clear_done = vt[i].clr;
            cyc();
            chk($sformatf("vec%0d Q", i),    32'(q1),    32'(vt[i].eq));
            chk($sformatf("vec%0d tc", i),   32'(tc1),   32'(vt[i].etc));
            chk($sformatf("vec%0d done", i), 32'(done1), 32'(vt[i].edone));
        end

        // Prescaler (dut4): ch2 limit=1 auto-reload, with an en gap mid-count
        idle_inputs();
        reset = 1'b0;
        cyc();
        reset = 1'b1; load = 4'h4; limit = pk(0,1,0,0); mode = 4'h4;
        cyc();
        load = '0; en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("ps k%0d Q2", k), 32'(q4[2*W +: W]), (k < 4) ? 32'd1 : 32'd0);
            chk($sformatf("ps k%0d tc", k), 32'(tc4), 32'd0);
        end
        cyc();
        cyc();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("ps hold%0d Q2", k), 32'(q4[2*W +: W]), 32'd0);
            chk($sformatf("ps hold%0d tc", k), 32'(tc4), 32'd0);
        end
        en = 1'b1;
        cyc();
        chk("ps resume Q2", 32'(q4[2*W +: W]), 32'd0);
        chk("ps resume tc", 32'(tc4), 32'd0);
        cyc();
        chk("ps reload Q2", 32'(q4[2*W +: W]), 32'd1);
        chk("ps reload tc", 32'(tc4), 32'h4);

        // Width / independence (dut1): ch0 limit=127, ch1 limit=0, both auto-reload
        idle_inputs();
        reset = 1'b0;
        cyc();
        reset = 1'b1; load = 4'h3; limit = pk(0,0,0,127); mode = 4'h3;
        cyc();
        chk("wid load Q", 32'(q1), 32'(pk(0,0,0,127)));
        load = '0; en = 1'b1;
        for (int k = 1; k <= 129; k++) begin
            cyc();
            exp0 = (k <= 127) ? W'(127 - k) : (k == 128 ? W'(127) : W'(126));
            chk($sformatf("wid k%0d Q0", k),  32'(q1[0 +: W]), 32'(exp0));
            chk($sformatf("wid k%0d Q1", k),  32'(q1[W +: W]), 32'd0);
            chk($sformatf("wid k%0d tc", k),  32'(tc1), (k == 128) ? 32'h3 : 32'h2);
            chk($sformatf("wid k%0d done", k), 32'(done1), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_channel_down_timer.md
Name: multi_channel_down_timer

Overview:
Parametrised successor to the team's single down-counter. Provides CHANNELS independent loadable down-counters of WIDTH bits, each selectable as one-shot or auto-reload, all advanced by a shared enable and prescaler. Each channel emits a one-cycle terminal-count pulse and a sticky done flag. Sits between the control FSM that loads limits and the timing logic that consumes tick/terminal events.

Parameters:
WIDTH, 7, bit width of each counter and limit
CHANNELS, 4, number of independent counter channels
PRESCALE, 1, number of enabled clk cycles per count tick (>=1; 1 means tick every enabled cycle)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge)
en  input  1  global count enable, gates the prescaler
load  input  CHANNELS  per-channel load strobe
limit  input  CHANNELS*WIDTH  per-channel load value, channel i at [i*WIDTH +: WIDTH]
mode  input  CHANNELS  per-channel mode: 0 = one-shot, 1 = auto-reload
clear_done  input  CHANNELS  per-channel done clear strobe
Q  output  CHANNELS*WIDTH  per-channel current count, registered
tc  output  CHANNELS  per-channel terminal-count pulse, registered, 1 cycle
done  output  CHANNELS  per-channel sticky one-shot completion flag

Behaviour:
- Reset (reset==0 at clk edge): Q=0, internal reload register=0, armed=0, done=0, tc=0, prescaler count=0. Reset overrides every other input. Reset mid-count abandons the count with no tc.
- Prescaler: shared counter 0..PRESCALE-1, advances only when en=1 and wraps to 0. tick=en && (pcount==PRESCALE-1). With PRESCALE=1, tick=en. The prescaler is not affected by load.
- Per channel i, priority per clk edge: load > tick > hold.
- load[i]=1: Q<=limit, reload<=limit, armed<=1, done<=0, tc<=0. mode is sampled continuously, not latched.
- tick, armed, Q!=0: Q<=Q-1, tc<=0.
- tick, armed, Q==0: tc<=1 for exactly one cycle. If mode=1, Q<=reload and armed stays 1; auto-reload period is reload+1 ticks, and reload=0 gives tc on every tick. If mode=0, Q holds 0, armed<=0, done<=1.
- Not armed (after reset or one-shot completion): Q holds and no tc is generated until the next load.
- Arithmetic is unsigned modulo 2^WIDTH. A decrement never occurs at 0, so there is no underflow wrap. Loading 0 then ticking gives tc on the first tick.
- No tick (en=0 or prescaler mid-count): Q holds and tc<=0.
- clear_done[i]=1: done<=0. If done is set in the same cycle, set wins. Load also clears done.
- Channels are fully independent; simultaneous tc on several channels is legal.
- Latency: Q and tc change on the clk edge that samples the tick; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: MODE_ONESHOT=1'b0, MODE_RELOAD=1'b1 constants, and the clog2-based prescaler width helper.
- Natural sub-module: down_timer_channel (WIDTH parameter; ports clk, reset, tick, load, limit, mode, clear_done, Q, tc, done), instantiated CHANNELS times in a generate loop. The top level holds only the prescaler and port slicing.

Test Plan:
- Reset: hold reset=0 for 2 cycles with load=all-1 and en=1 -> Q=0, tc=0, done=0 on all channels. Release -> Q stays 0 and no tc (not armed).
- One-shot, PRESCALE=1: ch0 load limit=3, mode=0, en=1 -> Q sequence 3,2,1,0. tc=1 on the tick where Q==0 is seen, then done=1. Q holds 0 with no further tc. clear_done -> done=0.
- Auto-reload: ch1 limit=2, mode=1, en=1 for 9 cycles -> Q 2,1,0,2,1,0,2,1,0. tc pulses every 3rd tick. done stays 0.
- Prescaler: PRESCALE=4, ch2 limit=1, mode=1 -> Q decrements once per 4 enabled cycles. Drop en for 5 cycles mid-count -> Q and prescaler hold, no tc.
- Priority: load on ch3 (limit=5) on the same cycle as its terminal tick -> Q=5, tc=0, done=0. clear_done coinciding with one-shot completion -> done=1.
- Independence and width: WIDTH=7, ch0 limit=127 and ch1 limit=0, both auto-reload -> ch1 tc every tick, ch0 tc after 128 ticks. No cross-channel interference.
